// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, FSM state encodings and
// instruction field positions. Optional Z flag is enabled with ALU_SEQ_ZFLAG_EN.
package alu_op_sequencer_pkg;

    localparam int INSTR_W = 12;
    localparam int REG_AW  = 3;
    localparam int OP_W    = 3;

    // Instruction layout: [11:9]=opcode, [8:6]=rd, [5:3]=rs1, [2:0]=rs2
    localparam int OP_LSB  = 9;
    localparam int RD_LSB  = 6;
    localparam int RS1_LSB = 3;
    localparam int RS2_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XNOR  = 3'b100,
        OP_NOTA  = 3'b101,
        OP_PASSA = 3'b110,
        OP_NOTB  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_LSB +: OP_W];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rs1(input logic [INSTR_W-1:0] instr);
        return instr[RS1_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rs2(input logic [INSTR_W-1:0] instr);
        return instr[RS2_LSB +: REG_AW];
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x W register file: two operand read ports, one debug read port and a
// per-register write mux where sequencer writeback takes priority over the host.
module alu_seq_regfile #(
    parameter int NREGS = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rs1_addr_i,
    output logic [W-1:0]  rs1_data_o,
    input  logic [AW-1:0] rs2_addr_i,
    output logic [W-1:0]  rs2_data_o,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [W-1:0]  dbg_data_o,
    input  logic          seq_we_i,
    input  logic [AW-1:0] seq_addr_i,
    input  logic [W-1:0]  seq_wdata_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [W-1:0]  host_wdata_i
);

    logic [W-1:0]              regs_q [NREGS];
    logic [NREGS-1:0]          we;
    logic [NREGS-1:0][W-1:0]   wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_wr
            if (gi == 0) begin : g_zero
                // Register 0 is hard-wired to zero; both write sources are dropped.
                assign we[gi]    = 1'b0;
                assign wdata[gi] = '0;
            end else begin : g_reg
                logic seq_hit;
                logic host_hit;
                assign seq_hit   = seq_we_i && (seq_addr_i == AW'(gi));
                assign host_hit  = host_we_i && (host_addr_i == AW'(gi));
                assign we[gi]    = seq_hit || host_hit;
                assign wdata[gi] = seq_hit ? seq_wdata_i : host_wdata_i;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we[i]) begin
                    regs_q[i] <= wdata[i];
                end
            end
        end
    end

    assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one instruction at a time to a combinational ALU (IDLE->EXEC->WB) and writes
// the result back. Defining ALU_SEQ_ZFLAG_EN adds a registered zero-result flag on port Z.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [OP_W-1:0]    F,
    output logic [W-1:0]       A,
    output logic [W-1:0]       B,
    input  logic [W-1:0]       R,
    output logic               res_valid,
    output logic [W-1:0]       res_data,
    output logic [REG_AW-1:0]  res_rd,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic               Z,
`endif
    input  logic               host_we,
    input  logic [REG_AW-1:0]  host_addr,
    input  logic [W-1:0]       host_wdata,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [W-1:0]       dbg_data
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     f_q, f_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                res_valid_q, res_valid_d;
    logic [W-1:0]        res_data_q, res_data_d;
    logic [REG_AW-1:0]   res_rd_q, res_rd_d;
`ifdef ALU_SEQ_ZFLAG_EN
    logic                z_q, z_d;
`endif

    logic                accept;
    logic                wb_we;
    logic [W-1:0]        rs1_data;
    logic [W-1:0]        rs2_data;

    alu_seq_regfile #(
        .NREGS (NREGS),
        .W     (W),
        .AW    (REG_AW)
    ) u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_addr_i   (instr_rs1(in_instr)),
        .rs1_data_o   (rs1_data),
        .rs2_addr_i   (instr_rs2(in_instr)),
        .rs2_data_o   (rs2_data),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_o   (dbg_data),
        .seq_we_i     (wb_we),
        .seq_addr_i   (rd_q),
        .seq_wdata_i  (R),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata)
    );

    // Ready is gated by reset so the host never sees a handshake while held in reset.
    assign in_ready = (state_q == S_IDLE) && rst_n;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        wb_we       = 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
        z_d         = z_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f_d     = instr_op(in_instr);
                    a_d     = rs1_data;
                    b_d     = rs2_data;
                    rd_d    = instr_rd(in_instr);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // The result is still reported for rd==0; only the register write is dropped.
                wb_we       = (rd_q != '0);
                res_valid_d = 1'b1;
                res_data_d  = R;
                res_rd_d    = rd_q;
`ifdef ALU_SEQ_ZFLAG_EN
                z_d         = (R == '0);
`endif
                state_d     = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            f_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
            z_q         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
`ifdef ALU_SEQ_ZFLAG_EN
            z_q         <= z_d;
`endif
        end
    end

    assign F         = f_q;
    assign A         = a_q;
    assign B         = b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
`ifdef ALU_SEQ_ZFLAG_EN
    assign Z         = z_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached to F/A/B/R.
// Results are checked through a scoreboard queue; Z is checked when ALU_SEQ_ZFLAG_EN is set.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_instr;
    logic [2:0]  F;
    logic [31:0] A, B, R;
    logic        res_valid;
    logic [31:0] res_data;
    logic [2:0]  res_rd;
    logic        host_we;
    logic [2:0]  host_addr;
    logic [31:0] host_wdata;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef ALU_SEQ_ZFLAG_EN
    logic        Z;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer #(.NREGS(8), .W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .F          (F),
        .A          (A),
        .B          (B),
        .R          (R),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_rd     (res_rd),
`ifdef ALU_SEQ_ZFLAG_EN
        .Z          (Z),
`endif
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Behavioural ALU
    always_comb begin
        case (F)
            3'b000:  R = A + B;
            3'b001:  R = A - B;
            3'b010:  R = A & B;
            3'b011:  R = A | B;
            3'b100:  R = ~(A ^ B);
            3'b101:  R = ~A;
            3'b110:  R = A;
            default: R = ~B;
        endcase
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  rd;
        int          due;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    typedef struct {
        logic [11:0] instr;
        logic [31:0] exp_data;
        logic [31:0] exp_dbg;
    } vec_t;
    vec_t vecs[10];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    endtask

    function automatic logic [11:0] enc(input logic [2:0] f, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {f, rd, rs1, rs2};
    endfunction

    // Scoreboard monitor: one line per completed result.
    always @(negedge clk) begin
        if (res_valid) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_res: got rd=%0d data=0x%08h expected no result", res_rd, res_data);
            end else begin
                mon_e = sbq.pop_front();
                $display("result rd=%0d data=0x%08h (expected rd=%0d data=0x%08h) cycle %0d",
                         res_rd, res_data, mon_e.rd, mon_e.data, cycle);
                check("res_data", res_data, mon_e.data);
                check("res_rd", 32'(res_rd), 32'(mon_e.rd));
                check("res_latency", 32'(cycle), 32'(mon_e.due));
            end
        end else if (sbq.size() > 0 && cycle > sbq[0].due) begin
            n_checks++;
            $display("FAIL missing_res: got no result expected rd=%0d data=0x%08h by cycle %0d",
                     sbq[0].rd, sbq[0].data, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
        host_we = 1'b1; host_addr = addr; host_wdata = data;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge of the EXEC cycle.
    task automatic issue(input logic [11:0] instr, input logic [31:0] exp, input bit push,
                         input bit keep, output int acc, output int waits);
        in_valid = 1'b1;
        in_instr = instr;
        waits    = 0;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        acc = cycle + 1;
        if (push) sbq.push_back('{data: exp, rd: instr[8:6], due: cycle + 2});
        $display("issue instr=0x%03h accept_cycle=%0d", instr, acc);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[4];
        int w[4];
        int a_tmp, w_tmp;

        vecs[0] = '{enc(OP_ADD,   3'd3, 3'd1, 3'd2), 32'd8,          32'd8};
        vecs[1] = '{enc(OP_SUB,   3'd4, 3'd2, 3'd1), 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        vecs[2] = '{enc(OP_NOTB,  3'd5, 3'd0, 3'd1), 32'hFFFF_FFFA, 32'hFFFF_FFFA};
        vecs[3] = '{enc(OP_PASSA, 3'd6, 3'd1, 3'd0), 32'd5,          32'd5};
        vecs[4] = '{enc(OP_ADD,   3'd0, 3'd1, 3'd2), 32'd8,          32'd0};
        vecs[5] = '{enc(OP_AND,   3'd7, 3'd1, 3'd2), 32'd1,          32'd1};
        vecs[6] = '{enc(OP_OR,    3'd7, 3'd1, 3'd2), 32'd7,          32'd7};
        vecs[7] = '{enc(OP_XNOR,  3'd7, 3'd1, 3'd2), 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        vecs[8] = '{enc(OP_NOTA,  3'd7, 3'd2, 3'd0), 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[9] = '{enc(OP_SUB,   3'd7, 3'd1, 3'd1), 32'd0,          32'd0};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0; dbg_addr = '0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_FAB", {29'd0, F} | A | B, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        host_write(3'd1, 32'd5);
        host_write(3'd2, 32'd3);
        host_write(3'd0, 32'hDEAD_BEEF);
        dbg_addr = 3'd0;
        #1 check("dbg_r0_host", dbg_data, 32'd0);

        // Table-driven single instructions
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].instr, vecs[i].exp_data, 1'b1, 1'b0, a_tmp, w_tmp);
            check("exec_F", 32'(F), 32'(vecs[i].instr[11:9]));
            check("exec_ready", 32'(in_ready), 32'd0);
            dbg_addr = vecs[i].instr[8:6];
            @(negedge clk);
            check("dbg_rd", dbg_data, vecs[i].exp_dbg);
`ifdef ALU_SEQ_ZFLAG_EN
            check("zflag", 32'(Z), 32'(vecs[i].exp_data == 32'd0));
`endif
        end

        // Back-to-back with in_valid held high
        issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2), 32'd8,  1'b1, 1'b1, acc[0], w[0]);
        issue(enc(OP_SUB, 3'd4, 3'd1, 3'd2), 32'd2,  1'b1, 1'b1, acc[1], w[1]);
        issue(enc(OP_OR,  3'd5, 3'd1, 3'd2), 32'd7,  1'b1, 1'b1, acc[2], w[2]);
        issue(enc(OP_ADD, 3'd6, 3'd3, 3'd4), 32'd10, 1'b1, 1'b0, acc[3], w[3]);
        for (int i = 1; i < 4; i++) begin
            check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
            check("b2b_ready_low", 32'(w[i]), 32'd2);
        end
        @(negedge clk);

        // Host write collides with writeback to the same register
        issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2), 32'd8, 1'b1, 1'b0, a_tmp, w_tmp);
        host_write(3'd3, 32'h55);
        dbg_addr = 3'd3;
        #1 check("wb_beats_host", dbg_data, 32'd8);
        @(negedge clk);

        // Host write to a source register after accept
        issue(enc(OP_ADD, 3'd7, 3'd1, 3'd2), 32'd8, 1'b1, 1'b0, a_tmp, w_tmp);
        host_write(3'd1, 32'd100);
        dbg_addr = 3'd1;
        #1 check("host_r1", dbg_data, 32'd100);
        @(negedge clk);

        // Reset during EXEC aborts the instruction
        issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2), 32'd0, 1'b0, 1'b0, a_tmp, w_tmp);
        rst_n = 1'b0;
        #1;
        check("abort_A", A, 32'd0);
        check("abort_B", B, 32'd0);
        check("abort_F", 32'(F), 32'd0);
        check("abort_res_data", res_data, 32'd0);
        check("abort_res_rd", 32'(res_rd), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        dbg_addr = 3'd1;
        @(negedge clk);
        check("abort_r1_clear", dbg_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready", 32'(in_ready), 32'd1);
        check("release_res_valid", 32'(res_valid), 32'd0);
        dbg_addr = 3'd3;
        repeat (3) @(negedge clk);
        check("abort_r3_clear", dbg_data, 32'd0);

        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
